// File: rtl/vga_timing_pkg.sv
// Shared phase encoding, 1024x768 timing constants and test-bar colour helper
// for the VGA timing sequencer.
package vga_timing_pkg;

    typedef enum logic [1:0] {
        PH_ACTIVE      = 2'd0,
        PH_FRONT_PORCH = 2'd1,
        PH_SYNC        = 2'd2,
        PH_BACK_PORCH  = 2'd3
    } phase_e;

    localparam int unsigned VGA_COUNTER_SIZE = 11;

    localparam int unsigned VGA_H_ACTIVE = 1024;
    localparam int unsigned VGA_H_FRONT  = 24;
    localparam int unsigned VGA_H_SYNC   = 136;
    localparam int unsigned VGA_H_BACK   = 144;
    localparam int unsigned VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int unsigned VGA_H_SYNC_START = VGA_H_ACTIVE + VGA_H_FRONT;
    localparam int unsigned VGA_H_BACK_START = VGA_H_SYNC_START + VGA_H_SYNC;

    localparam int unsigned VGA_V_ACTIVE = 768;
    localparam int unsigned VGA_V_FRONT  = 3;
    localparam int unsigned VGA_V_SYNC   = 6;
    localparam int unsigned VGA_V_BACK   = 29;
    localparam int unsigned VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;
    localparam int unsigned VGA_V_SYNC_START = VGA_V_ACTIVE + VGA_V_FRONT;
    localparam int unsigned VGA_V_BACK_START = VGA_V_SYNC_START + VGA_V_SYNC;

    localparam int unsigned VGA_RGB_W = 12;

    // Each index bit lights one full colour channel: bit2=R, bit1=G, bit0=B.
    function automatic logic [VGA_RGB_W-1:0] vga_bar_rgb(input logic [2:0] idx);
        return {{4{idx[2]}}, {4{idx[1]}}, {4{idx[0]}}};
    endfunction

endpackage

// File: rtl/vga_axis_phase_tracker.sv
// One display axis: ACTIVE/FRONT/SYNC/BACK phase tracking from the counter
// value, plus range and zero-flag consistency checking.
module vga_axis_phase_tracker
    import vga_timing_pkg::*;
#(
    parameter int unsigned W      = VGA_COUNTER_SIZE,
    parameter int unsigned ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned FRONT  = VGA_H_FRONT,
    parameter int unsigned SYNC   = VGA_H_SYNC,
    parameter int unsigned BACK   = VGA_H_BACK
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic [W-1:0] count_i,
    input  logic         zero_i,
    output phase_e       next_phase_c_o,
    output logic         error_c_o
);

    localparam int unsigned TOTAL = ACTIVE + FRONT + SYNC + BACK;

    localparam logic [W-1:0] FRONT_START = W'(ACTIVE);
    localparam logic [W-1:0] SYNC_START  = W'(ACTIVE + FRONT);
    localparam logic [W-1:0] BACK_START  = W'(ACTIVE + FRONT + SYNC);
    localparam logic [W-1:0] COUNT_LIMIT = W'(TOTAL);

    phase_e phase_q;
    phase_e phase_d;
    logic   count_is_zero;

    assign count_is_zero = (count_i == '0);

    // Phase only moves on a boundary value; any other count holds the phase.
    always_comb begin
        phase_d = phase_q;
        if (en_i) begin
            if (count_is_zero) begin
                phase_d = PH_ACTIVE;
            end else if (count_i == FRONT_START) begin
                phase_d = PH_FRONT_PORCH;
            end else if (count_i == SYNC_START) begin
                phase_d = PH_SYNC;
            end else if (count_i == BACK_START) begin
                phase_d = PH_BACK_PORCH;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q <= PH_BACK_PORCH;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign next_phase_c_o = phase_d;
    assign error_c_o      = (count_i >= COUNT_LIMIT) || (zero_i != count_is_zero);

endmodule

// File: rtl/vga_timing_sequencer.sv
// VGA sync/blanking sequencer driven by external h/v counters.
// Define VGA_TEST_PATTERN_EN to add the 8-bar test_rgb output.
module vga_timing_sequencer
    import vga_timing_pkg::*;
#(
    parameter int unsigned COUNTER_SIZE    = VGA_COUNTER_SIZE,
    parameter int unsigned H_ACTIVE        = VGA_H_ACTIVE,
    parameter int unsigned H_FRONT         = VGA_H_FRONT,
    parameter int unsigned H_SYNC          = VGA_H_SYNC,
    parameter int unsigned H_BACK          = VGA_H_BACK,
    parameter int unsigned V_ACTIVE        = VGA_V_ACTIVE,
    parameter int unsigned V_FRONT         = VGA_V_FRONT,
    parameter int unsigned V_SYNC          = VGA_V_SYNC,
    parameter int unsigned V_BACK          = VGA_V_BACK,
    parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic                    control_clock,
    input  logic                    control_reset_n,
    input  logic                    pixel_enable,
    input  logic [COUNTER_SIZE-1:0] h_counter_in,
    input  logic                    h_zero_detected,
    input  logic [COUNTER_SIZE-1:0] v_counter_in,
    input  logic                    v_zero_detected,
    output logic                    line_end_pulse,
    output logic                    hsync,
    output logic                    vsync,
    output logic                    display_enable,
    output logic [COUNTER_SIZE-1:0] pixel_x,
    output logic [COUNTER_SIZE-1:0] pixel_y,
    output logic                    frame_start,
`ifdef VGA_TEST_PATTERN_EN
    output logic [VGA_RGB_W-1:0]    test_rgb,
`endif
    output logic                    timing_error
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam logic [COUNTER_SIZE-1:0] H_LAST = COUNTER_SIZE'(H_TOTAL - 1);

    phase_e h_next;
    phase_e v_next;
    logic   h_err;
    logic   v_err;

    vga_axis_phase_tracker #(
        .W      (COUNTER_SIZE),
        .ACTIVE (H_ACTIVE),
        .FRONT  (H_FRONT),
        .SYNC   (H_SYNC),
        .BACK   (H_BACK)
    ) u_h_axis (
        .clk_i          (control_clock),
        .rst_ni         (control_reset_n),
        .en_i           (pixel_enable),
        .count_i        (h_counter_in),
        .zero_i         (h_zero_detected),
        .next_phase_c_o (h_next),
        .error_c_o      (h_err)
    );

    vga_axis_phase_tracker #(
        .W      (COUNTER_SIZE),
        .ACTIVE (V_ACTIVE),
        .FRONT  (V_FRONT),
        .SYNC   (V_SYNC),
        .BACK   (V_BACK)
    ) u_v_axis (
        .clk_i          (control_clock),
        .rst_ni         (control_reset_n),
        .en_i           (pixel_enable),
        .count_i        (v_counter_in),
        .zero_i         (v_zero_detected),
        .next_phase_c_o (v_next),
        .error_c_o      (v_err)
    );

    // Zero-latency so the vertical counter steps on the same edge h wraps.
    assign line_end_pulse = pixel_enable && (h_counter_in == H_LAST);

    logic                    hsync_q, hsync_d;
    logic                    vsync_q, vsync_d;
    logic                    de_q, de_d;
    logic [COUNTER_SIZE-1:0] px_q, px_d;
    logic [COUNTER_SIZE-1:0] py_q, py_d;
    logic                    fs_q, fs_d;
    logic                    err_q, err_d;
`ifdef VGA_TEST_PATTERN_EN
    logic [VGA_RGB_W-1:0]    rgb_q, rgb_d;
`endif

    // Outputs are decoded from the phase being loaded this edge (1-cycle latency).
    always_comb begin
        hsync_d = (h_next == PH_SYNC) ^ SYNC_ACTIVE_LOW;
        vsync_d = (v_next == PH_SYNC) ^ SYNC_ACTIVE_LOW;
        de_d    = (h_next == PH_ACTIVE) && (v_next == PH_ACTIVE);
        px_d    = de_d ? h_counter_in : '0;
        py_d    = de_d ? v_counter_in : '0;
        fs_d    = pixel_enable && (h_counter_in == '0) && (v_counter_in == '0);
        err_d   = err_q || h_err || v_err;
`ifdef VGA_TEST_PATTERN_EN
        rgb_d   = de_d ? vga_bar_rgb(h_counter_in[9:7]) : '0;
`endif
    end

    always_ff @(posedge control_clock or negedge control_reset_n) begin
        if (!control_reset_n) begin
            hsync_q <= SYNC_ACTIVE_LOW;
            vsync_q <= SYNC_ACTIVE_LOW;
            de_q    <= 1'b0;
            px_q    <= '0;
            py_q    <= '0;
            fs_q    <= 1'b0;
            err_q   <= 1'b0;
`ifdef VGA_TEST_PATTERN_EN
            rgb_q   <= '0;
`endif
        end else begin
            fs_q <= fs_d;
            if (pixel_enable) begin
                hsync_q <= hsync_d;
                vsync_q <= vsync_d;
                de_q    <= de_d;
                px_q    <= px_d;
                py_q    <= py_d;
                err_q   <= err_d;
`ifdef VGA_TEST_PATTERN_EN
                rgb_q   <= rgb_d;
`endif
            end
        end
    end

    assign hsync          = hsync_q;
    assign vsync          = vsync_q;
    assign display_enable = de_q;
    assign pixel_x        = px_q;
    assign pixel_y        = py_q;
    assign frame_start    = fs_q;
    assign timing_error   = err_q;
`ifdef VGA_TEST_PATTERN_EN
    assign test_rgb       = rgb_q;
`endif

endmodule

// File: tb/tb_vga_timing_sequencer.sv
// Self-checking bench for vga_timing_sequencer: directed vector table, sync
// width sequences, error/reset corner cases and a randomized model comparison.
`timescale 1ns/1ps
module tb_vga_timing_sequencer;

    localparam int HA = 1024, HF = 24, HS = 136, HT = 1328;
    localparam int VA = 768,  VF = 3,  VS = 6,   VT = 806;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pe;
    logic [10:0] h_in, v_in;
    logic        hz, vz;
    logic        line_end_pulse, hsync, vsync, display_enable, frame_start, timing_error;
    logic [10:0] pixel_x, pixel_y;
`ifdef VGA_TEST_PATTERN_EN
    logic [11:0] test_rgb;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vga_timing_sequencer dut (
        .control_clock   (clk),
        .control_reset_n (rst_n),
        .pixel_enable    (pe),
        .h_counter_in    (h_in),
        .h_zero_detected (hz),
        .v_counter_in    (v_in),
        .v_zero_detected (vz),
        .line_end_pulse  (line_end_pulse),
        .hsync           (hsync),
        .vsync           (vsync),
        .display_enable  (display_enable),
        .pixel_x         (pixel_x),
        .pixel_y         (pixel_y),
        .frame_start     (frame_start),
`ifdef VGA_TEST_PATTERN_EN
        .test_rgb        (test_rgb),
`endif
        .timing_error    (timing_error)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] bars(input int x);
        int idx;
        logic [11:0] c;
        idx = (x / 128) % 8;
        c = 12'h000;
        if (idx >= 4)       c = c | 12'hF00;
        if ((idx / 2) % 2)  c = c | 12'h0F0;
        if (idx % 2)        c = c | 12'h00F;
        return c;
    endfunction

    task automatic check_all(input string tag, input bit e_de, input bit e_hs, input bit e_vs,
                             input int e_px, input int e_py, input bit e_fs, input bit e_err);
        chk({tag, ".de"},  32'(display_enable), 32'(e_de));
        chk({tag, ".hs"},  32'(hsync),          32'(e_hs));
        chk({tag, ".vs"},  32'(vsync),          32'(e_vs));
        chk({tag, ".px"},  32'(pixel_x),        32'(e_px));
        chk({tag, ".py"},  32'(pixel_y),        32'(e_py));
        chk({tag, ".fs"},  32'(frame_start),    32'(e_fs));
        chk({tag, ".err"}, 32'(timing_error),   32'(e_err));
`ifdef VGA_TEST_PATTERN_EN
        chk({tag, ".rgb"}, 32'(test_rgb), 32'(e_de ? bars(e_px) : 12'h000));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit p, input int hc, input int vc);
        pe   = p;
        h_in = 11'(hc);
        v_in = 11'(vc);
        hz   = (hc == 0);
        vz   = (vc == 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 0, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Phase after sampling count c: boundaries enter a phase, other counts keep it.
    // 0=ACTIVE 1=FRONT 2=SYNC 3=BACK
    function automatic int phase_after(input int c, input int a, input int f, input int s, input int cur);
        int starts[4];
        starts = '{0, a, a + f, a + f + s};
        for (int i = 0; i < 4; i++) if (c == starts[i]) return i;
        return cur;
    endfunction

    function automatic int pick_h();
        int opts[10];
        int k;
        opts = '{0, 1, 1023, 1024, 1047, 1048, 1183, 1184, 1320, 1327};
        k = $urandom_range(0, 11);
        return (k < 10) ? opts[k] : int'($urandom_range(0, HT - 1));
    endfunction

    function automatic int pick_v();
        int opts[8];
        int k;
        opts = '{0, 1, 767, 768, 770, 771, 776, 777};
        k = $urandom_range(0, 9);
        return (k < 8) ? opts[k] : int'($urandom_range(0, VT - 1));
    endfunction

    typedef struct {
        bit pe; int h; int v;
        bit le; bit de; bit hs; bit vs; int px; int py; bit fs;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int lowcnt, first, vlow, vfirst, dehi;
        int hc, vc, hph, vph, e_px, e_py;
        bit p, e_de, e_hs, e_vs, e_fs;

        // Directed vectors applied in order from reset (both axes in BACK_PORCH)
        tbl.push_back('{1, 0,    0,   0, 1, 1, 1, 0,    0,   1});
        tbl.push_back('{1, 1,    0,   0, 1, 1, 1, 1,    0,   0});
        tbl.push_back('{0, 2,    0,   0, 1, 1, 1, 1,    0,   0});
        tbl.push_back('{1, 1023, 0,   0, 1, 1, 1, 1023, 0,   0});
        tbl.push_back('{1, 1024, 0,   0, 0, 1, 1, 0,    0,   0});
        tbl.push_back('{1, 1048, 0,   0, 0, 0, 1, 0,    0,   0});
        tbl.push_back('{1, 1184, 0,   0, 0, 1, 1, 0,    0,   0});
        tbl.push_back('{0, 1327, 0,   0, 0, 1, 1, 0,    0,   0});
        tbl.push_back('{1, 1327, 0,   1, 0, 1, 1, 0,    0,   0});
        tbl.push_back('{1, 0,    1,   0, 1, 1, 1, 0,    1,   0});
        tbl.push_back('{1, 300,  767, 0, 1, 1, 1, 300,  767, 0});
        tbl.push_back('{1, 5,    768, 0, 0, 1, 1, 0,    0,   0});
        tbl.push_back('{1, 6,    771, 0, 0, 1, 0, 0,    0,   0});
        tbl.push_back('{0, 0,    0,   0, 0, 1, 0, 0,    0,   0});
        tbl.push_back('{1, 7,    777, 0, 0, 1, 1, 0,    0,   0});

        rst_n = 1'b0;
        drive(1'b0, 0, 0);
        do_reset();
        check_all("reset", 0, 1, 1, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].pe, tbl[i].h, tbl[i].v);
            #1;
            chk($sformatf("vec%0d.le", i), 32'(line_end_pulse), 32'(tbl[i].le));
            tick();
            check_all($sformatf("vec%0d", i), tbl[i].de, tbl[i].hs, tbl[i].vs,
                      tbl[i].px, tbl[i].py, tbl[i].fs, 0);
        end

        // hsync pulse width and start position
        do_reset();
        lowcnt = 0; first = -1;
        for (int k = 1040; k <= 1200; k++) begin
            drive(1'b1, k, 0);
            tick();
            if (!hsync) begin
                lowcnt++;
                if (first < 0) first = k;
            end
        end
        chk("hsync.width", 32'(lowcnt), 32'(HS));
        chk("hsync.first", 32'(first), 32'(HA + HF));

        // vsync over full lines 769..778; no display in vertical blanking
        do_reset();
        vlow = 0; vfirst = -1; dehi = 0;
        for (int vv = 769; vv <= 778; vv++) begin
            for (int k = 0; k < HT; k++) begin
                drive(1'b1, k, vv);
                tick();
                if (!vsync) begin
                    vlow++;
                    if (vfirst < 0) vfirst = vv;
                end
                if (display_enable) dehi++;
            end
        end
        chk("vsync.cycles", 32'(vlow), 32'(VS * HT));
        chk("vsync.first", 32'(vfirst), 32'(VA + VF));
        chk("vblank.de", 32'(dehi), 32'(0));

        // Sticky timing_error sources
        do_reset();
        drive(1'b1, 5, 0);
        hz = 1'b1;
        tick();
        chk("err.hzero", 32'(timing_error), 32'(1));
        for (int k = 6; k < 9; k++) begin
            drive(1'b1, k, 0);
            tick();
        end
        chk("err.sticky", 32'(timing_error), 32'(1));
        do_reset();
        chk("err.cleared", 32'(timing_error), 32'(0));
        drive(1'b1, 1400, 0);
        tick();
        chk("err.hrange", 32'(timing_error), 32'(1));
        do_reset();
        drive(1'b1, 10, 900);
        tick();
        chk("err.vrange", 32'(timing_error), 32'(1));
        do_reset();
        drive(1'b1, 10, 0);
        vz = 1'b0;
        tick();
        chk("err.vzero", 32'(timing_error), 32'(1));

        // Reset in mid-frame, then restart from zero
        do_reset();
        drive(1'b1, 0, 0);
        tick();
        drive(1'b1, 500, 300);
        tick();
        check_all("mid", 1, 1, 1, 500, 300, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("mid.async", 0, 1, 1, 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1100 + k, 0);
            tick();
            check_all($sformatf("mid.nosync%0d", k), 0, 1, 1, 0, 0, 0, 0);
        end
        drive(1'b1, 0, 0);
        tick();
        check_all("mid.restart", 1, 1, 1, 0, 0, 1, 0);
        drive(1'b1, 1, 0);
        tick();
        check_all("mid.next", 1, 1, 1, 1, 0, 0, 0);

        // Randomized raster with stalls and jumps against the phase model
        do_reset();
        hph = 3; vph = 3;
        e_de = 0; e_hs = 1; e_vs = 1; e_px = 0; e_py = 0;
        hc = 0; vc = 0;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                hc = pick_h();
                vc = pick_v();
            end
            p = ($urandom_range(0, 3) != 0);
            drive(p, hc, vc);
            #1;
            chk("rnd.le", 32'(line_end_pulse), 32'(p && hc == HT - 1));
            e_fs = p && hc == 0 && vc == 0;
            if (p) begin
                hph  = phase_after(hc, HA, HF, HS, hph);
                vph  = phase_after(vc, VA, VF, VS, vph);
                e_de = (hph == 0) && (vph == 0);
                e_px = e_de ? hc : 0;
                e_py = e_de ? vc : 0;
                e_hs = (hph != 2);
                e_vs = (vph != 2);
            end
            tick();
            check_all("rnd", e_de, e_hs, e_vs, e_px, e_py, e_fs, 0);
            if (p) begin
                if (hc == HT - 1) begin
                    hc = 0;
                    vc = (vc == VT - 1) ? 0 : vc + 1;
                end else begin
                    hc++;
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
